// File: rtl/svm_ctrl_pkg.sv
// Shared control definitions for the release scheduler and its downstream delay counter:
// FSM state encoding, count width and the saturating in-flight counter step.
package svm_ctrl_pkg;

  // Must match the width of the downstream delay counter.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  // +1 on capture only, -1 on release only, hold otherwise; clamps at 0 and max_cnt.
  function automatic logic [CNT_W-1:0] step_count(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic             dec,
    input logic [CNT_W-1:0] max_cnt
  );
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (inc && !dec && (cnt != max_cnt)) begin
      nxt = cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      nxt = cnt - 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/release_scheduler_if.sv
// Upstream item handshake plus drain request for the release scheduler.
interface release_scheduler_if;
  logic in_valid;
  logic in_ready;
  logic drain_req;

  modport master (
    output in_valid,
    output drain_req,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  drain_req,
    output in_ready
  );
endinterface

// File: rtl/pulse_delay_line.sv
// Single-bit shift register: a pulse on in reappears on out DEPTH cycles later.
module pulse_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  // NOTE: every bit of stage_d is assigned on every pass, so no latch is inferred.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: the line is reset (not left to flush) so releases scheduled before rst are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out = stage_q[DEPTH-1];

endmodule

// File: rtl/release_scheduler.sv
// Accepts items, pulses capture_l one cycle later and release_l LATENCY cycles after that,
// tracks the in-flight count and supports a drain that empties the pipeline.
module release_scheduler
  import svm_ctrl_pkg::*;
#(
  parameter int LATENCY      = 4,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                clk,
  input  logic                rst,
  release_scheduler_if.slave  bus,
  output logic                capture_l,
  output logic                release_l,
  output logic [CNT_W-1:0]    inflight,
  output logic                drain_done
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W:0]   MAX_OUT = (CNT_W+1)'(MAX_INFLIGHT);

  state_e           state_q,      state_d;
  logic             capture_q,    capture_d;
  logic [CNT_W-1:0] inflight_q,   inflight_d;
  logic             drain_done_q, drain_done_d;

  logic             release_w;
  logic             in_ready_w;
  logic             accept;
  logic [CNT_W:0]   outstanding;
  logic [CNT_W:0]   outstanding_next;

  // Outstanding = counted in-flight items plus an acceptance whose capture is still registered.
  assign outstanding = {1'b0, inflight_q} + {{CNT_W{1'b0}}, capture_q};
  assign in_ready_w  = (state_q != DRAIN) && (outstanding < MAX_OUT);
  // A drain request wins over an item offered in the same cycle.
  assign accept      = bus.in_valid && in_ready_w && !bus.drain_req;

  always_comb begin
    capture_d        = accept;
    inflight_d       = step_count(inflight_q, capture_q, release_w, MAX_CNT);
    outstanding_next = {1'b0, inflight_d} + {{CNT_W{1'b0}}, accept};
    state_d          = state_q;
    drain_done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.drain_req) begin
          drain_done_d = 1'b1;
        end else if (accept) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.drain_req) begin
          state_d = DRAIN;
        end else if (outstanding_next == '0) begin
          state_d = IDLE;
        end else if (outstanding_next >= MAX_OUT) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (bus.drain_req) begin
          state_d = DRAIN;
        end else if (release_w) begin
          state_d = ACTIVE;
        end
      end
      DRAIN: begin
        // in_ready is low here, so nothing new can be captured while waiting.
        if (outstanding_next == '0) begin
          state_d      = IDLE;
          drain_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      capture_q    <= 1'b0;
      inflight_q   <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      capture_q    <= capture_d;
      inflight_q   <= inflight_d;
      drain_done_q <= drain_done_d;
    end
  end

  // Fed from the registered capture so release lands exactly LATENCY cycles after capture_l.
  pulse_delay_line #(
    .DEPTH (LATENCY)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .in  (capture_q),
    .out (release_w)
  );

  assign bus.in_ready = in_ready_w;
  assign capture_l    = capture_q;
  assign release_l    = release_w;
  assign inflight     = inflight_q;
  assign drain_done   = drain_done_q;

endmodule

// File: tb/tb_release_scheduler.sv
// Self-checking bench: three scheduler instances (LATENCY 4, 32, 1) share one stimulus stream
// and are compared every cycle against a window-count reference model of acceptance times.
module tb_release_scheduler;
  import svm_ctrl_pkg::*;

  localparam int NI   = 3;
  localparam int MAXI = 16;
  localparam int HIST = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid;
  logic drain_req;

  logic             cap_o  [NI];
  logic             rel_o  [NI];
  logic             done_o [NI];
  logic             rdy_o  [NI];
  logic [CNT_W-1:0] inf_o  [NI];

  release_scheduler_if bus0 ();
  release_scheduler_if bus1 ();
  release_scheduler_if bus2 ();

  assign bus0.in_valid  = in_valid;
  assign bus1.in_valid  = in_valid;
  assign bus2.in_valid  = in_valid;
  assign bus0.drain_req = drain_req;
  assign bus1.drain_req = drain_req;
  assign bus2.drain_req = drain_req;
  assign rdy_o[0] = bus0.in_ready;
  assign rdy_o[1] = bus1.in_ready;
  assign rdy_o[2] = bus2.in_ready;

  release_scheduler #(.LATENCY(4), .MAX_INFLIGHT(MAXI)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0),
    .capture_l (cap_o[0]), .release_l (rel_o[0]), .inflight (inf_o[0]), .drain_done (done_o[0])
  );
  release_scheduler #(.LATENCY(32), .MAX_INFLIGHT(MAXI)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1),
    .capture_l (cap_o[1]), .release_l (rel_o[1]), .inflight (inf_o[1]), .drain_done (done_o[1])
  );
  release_scheduler #(.LATENCY(1), .MAX_INFLIGHT(MAXI)) u_dut2 (
    .clk (clk), .rst (rst), .bus (bus2),
    .capture_l (cap_o[2]), .release_l (rel_o[2]), .inflight (inf_o[2]), .drain_done (done_o[2])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: which cycles each instance accepted an item in, plus drain bookkeeping.
  bit acc_at    [NI][HIST];
  int floor_c   [NI];
  bit drain_m   [NI];
  int done_at   [NI];
  // Observed pulse counters and the downstream delay counter fed by the DUT pulses.
  int cap_seen  [NI];
  int rel_seen  [NI];
  int done_seen [NI];
  int done_inf  [NI];
  int ds_cnt    [NI];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    case (i)
      0:       return 4;
      1:       return 32;
      default: return 1;
    endcase
  endfunction

  // Number of accepted items with acceptance cycle in [lo, hi], ignoring anything before reset.
  function automatic int win(input int i, input int lo, input int hi);
    int n;
    int start;
    n     = 0;
    start = (lo > floor_c[i]) ? lo : floor_c[i];
    for (int k = start; k <= hi; k++) begin
      if (k >= 0 && k < HIST && acc_at[i][k]) n++;
    end
    return n;
  endfunction

  always @(posedge clk) cyc++;

  task automatic step_model(input int i);
    int  c;
    int  l;
    bit  rdy_e;
    c = cyc;
    l = lat_of(i);
    if (rst) begin
      check($sformatf("rst_cap%0d@%0d", i, c),  32'(cap_o[i]),  32'd0);
      check($sformatf("rst_rel%0d@%0d", i, c),  32'(rel_o[i]),  32'd0);
      check($sformatf("rst_inf%0d@%0d", i, c),  32'(inf_o[i]),  32'd0);
      check($sformatf("rst_done%0d@%0d", i, c), 32'(done_o[i]), 32'd0);
      floor_c[i] = c + 1;
      drain_m[i] = 1'b0;
      done_at[i] = -1;
      ds_cnt[i]  = 0;
    end else begin
      // Capture one cycle after acceptance, release LATENCY cycles after capture.
      rdy_e = !drain_m[i] && (win(i, c - 1 - l, c - 1) < MAXI);
      check($sformatf("cap%0d@%0d", i, c),  32'(cap_o[i]),  32'(win(i, c - 1, c - 1)));
      check($sformatf("rel%0d@%0d", i, c),  32'(rel_o[i]),  32'(win(i, c - 1 - l, c - 1 - l)));
      check($sformatf("inf%0d@%0d", i, c),  32'(inf_o[i]),  32'(win(i, c - 1 - l, c - 2)));
      check($sformatf("rdy%0d@%0d", i, c),  32'(rdy_o[i]),  32'(rdy_e));
      check($sformatf("done%0d@%0d", i, c), 32'(done_o[i]), 32'(done_at[i] == c));

      cap_seen[i]  += int'(cap_o[i]);
      rel_seen[i]  += int'(rel_o[i]);
      done_seen[i] += int'(done_o[i]);
      if (done_o[i]) done_inf[i] = int'(inf_o[i]);
      ds_cnt[i] += int'(cap_o[i]) - int'(rel_o[i]);

      if (in_valid && rdy_e && !drain_req && c < HIST) acc_at[i][c] = 1'b1;

      if (!drain_m[i]) begin
        if (drain_req) begin
          if (win(i, c - 1 - l, c - 1) == 0) done_at[i] = c + 1;
          else                                drain_m[i] = 1'b1;
        end
      end else if (win(i, c - l, c) == 0) begin
        drain_m[i] = 1'b0;
        done_at[i] = c + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) step_model(i);
  end

  task automatic drive(input int n, input logic v, input logic d);
    for (int k = 0; k < n; k++) begin
      in_valid  = v;
      drain_req = d;
      @(posedge clk);
      #1;
    end
  endtask

  int base_c;
  int base_r;
  int base_d;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    drain_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single item.
    drive(8, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0);
    drive(40, 1'b0, 1'b0);

    // Burst into the LATENCY=32 instance: only MAX_INFLIGHT items get in.
    base_c = cap_seen[1];
    drive(20, 1'b1, 1'b0);
    drive(2, 1'b0, 1'b0);
    check("burst_caps", 32'(cap_seen[1] - base_c), 32'd16);
    drive(45, 1'b0, 1'b0);

    // Continuous offer: LATENCY=1 instance captures and releases every cycle.
    drive(30, 1'b1, 1'b0);
    drive(45, 1'b0, 1'b0);

    // Drain with 5 items in flight while the upstream keeps offering.
    base_c = cap_seen[1];
    base_r = rel_seen[1];
    base_d = done_seen[1];
    drive(5, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b1);
    in_valid  = 1'b1;
    drain_req = 1'b0;
    for (int k = 0; k < 80 && done_seen[1] == base_d; k++) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("drain_done", 32'(done_seen[1] - base_d), 32'd1);
    check("drain_rels", 32'(rel_seen[1] - base_r), 32'd5);
    check("drain_caps", 32'(cap_seen[1] - base_c), 32'd5);
    check("drain_infl", 32'(done_inf[1]), 32'd0);
    drive(45, 1'b0, 1'b0);

    // Drain request while idle, then a second one.
    drive(1, 1'b0, 1'b1);
    drive(3, 1'b0, 1'b0);

    // Reset mid-flight: scheduled releases must vanish.
    base_r = rel_seen[1];
    drive(3, 1'b1, 1'b0);
    drive(2, 1'b0, 1'b0);
    rst = 1'b1;
    drive(2, 1'b0, 1'b0);
    rst = 1'b0;
    drive(45, 1'b0, 1'b0);
    check("rst_rels", 32'(rel_seen[1] - base_r), 32'd0);

    // Random traffic with occasional drains.
    for (int k = 0; k < 1000; k++) begin
      drive(1, logic'($urandom_range(0, 99) < 60), logic'($urandom_range(0, 99) < 3));
    end
    drive(50, 1'b0, 1'b0);

    // Downstream delay counter must be back at zero once nothing is in flight.
    for (int i = 0; i < NI; i++) begin
      check($sformatf("ds_cnt%0d", i), 32'(ds_cnt[i]), 32'd0);
      check($sformatf("end_inf%0d", i), 32'(inf_o[i]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/release_scheduler.md
RELEASE_SCHEDULER -- requirements
Module: release_scheduler

Interface
REQ-001 SHALL have parameter LATENCY, default 4, cycles from capture_l pulse to matching release_l pulse; legal 1..32.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 16, maximum outstanding captures; legal 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream offers one item this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts an item this cycle.
REQ-007 SHALL have port drain_req  input  1  single-cycle request to stop accepting and empty in-flight items.
REQ-008 SHALL have port capture_l  output  1  one-cycle pulse per accepted item, to the downstream delay counter.
REQ-009 SHALL have port release_l  output  1  one-cycle pulse per retired item, to the downstream delay counter.
REQ-010 SHALL have port inflight  output  8  count of captured, not-yet-released items.
REQ-011 SHALL have port drain_done  output  1  one-cycle pulse when a drain completes.

Function
REQ-012 SHALL accept an item in cycle t when in_valid and in_ready are both high in t.
REQ-013 SHALL drive capture_l high for exactly cycle t+1 after acceptance in t, from a register.
REQ-014 SHALL drive release_l high for exactly cycle t+1+LATENCY for each acceptance in t, from a register.
REQ-015 SHALL support back-to-back acceptances; each produces its own capture_l and release_l pulse with no merging or loss.
REQ-016 SHALL permit capture_l and release_l high in the same cycle.
REQ-017 SHALL update inflight: +1 on a capture_l pulse, -1 on a release_l pulse, unchanged when both or neither occur; never wrap below 0 or above MAX_INFLIGHT.
REQ-018 SHALL compute in_ready combinationally as (state != DRAIN) and (inflight + pending capture < MAX_INFLIGHT), where pending capture is an acceptance in t-1 whose capture_l is still registered.
REQ-019 SHALL implement FSM states IDLE, ACTIVE, FULL, DRAIN.
REQ-020 IDLE: inflight 0, no pending capture; acceptance -> ACTIVE; drain_req -> drain_done pulse next cycle, stay IDLE.
REQ-021 ACTIVE: in_ready per REQ-018; in_ready low due to count -> FULL; all outstanding released and no acceptance -> IDLE; drain_req -> DRAIN.
REQ-022 FULL: in_ready low; a release_l pulse -> ACTIVE; drain_req -> DRAIN.
REQ-023 DRAIN: in_ready low; releases continue on schedule; inflight reaching 0 with no pending capture -> IDLE with drain_done pulse in the same cycle as the transition.
REQ-024 SHALL give drain_req priority over acceptance in the same cycle: that cycle's item is not accepted.
REQ-025 SHALL ignore drain_req while already in DRAIN.

Reset
REQ-026 SHALL on rst assert: state IDLE, delay line cleared, capture_l 0, release_l 0, inflight 0, drain_done 0; in_ready 1 once rst deasserts.
REQ-027 SHALL, on reset mid-operation, discard all scheduled releases; no release_l pulse after rst for items accepted before it.

Structure
REQ-028 SHALL place the FSM state enum and the 8-bit count width constant in shared package svm_ctrl_pkg.
REQ-029 SHALL implement the LATENCY-stage single-bit shift register as sub-module pulse_delay_line (params DEPTH; ports clk, rst, in, out).
REQ-030 SHALL keep the count width equal to the downstream delay counter width (8 bits).

Verification
REQ-031 Single item, LATENCY=4: in_valid for 1 cycle at t=10 -> capture_l at 11, release_l at 15, inflight 1 during 12..15, 0 from 16.
REQ-032 Burst: in_valid held 20 cycles, MAX_INFLIGHT=16, LATENCY=32 -> 16 captures, in_ready low after 16th acceptance, FULL; first release_l re-raises in_ready.
REQ-033 Overlap: LATENCY=1, continuous in_valid -> capture_l and release_l both high every cycle from cycle 3; inflight steady at 1.
REQ-034 Drain: 5 items in flight, drain_req pulse, in_valid held high -> no further acceptances, 5 release_l pulses, drain_done coincident with transition to IDLE, inflight 0.
REQ-035 Reset mid-flight: 3 items accepted, rst asserted 2 cycles later -> all outputs 0, no release_l ever observed for those items.
REQ-036 End-to-end: connect to the downstream delay counter; random in_valid 1000 cycles -> counter returns to 0 when inflight reaches 0.
